// File: rtl/fpu_issue_ctrl.sv
// fpu_issue_ctrl: issue/completion controller for the multi-cycle FP units.
// It accepts one FP op and latches its operands. It then pulses the start
// line of the selected unit and stalls the pipeline until that unit reports
// done or the per-op timeout expires. Finally it returns a registered result
// with a one-cycle strobe. Illegal opcodes complete at once with an error code.
//
// Handshake with the core: an op is presented by holding op_valid high with a
// non-zero op_code. The core must keep op_valid/op_code/op_a/op_b stable while
// stall is high. The op is consumed at the end of the first cycle in which
// stall is low after acceptance, which is the DONE cycle carrying res_valid.
// The unit side uses a one-cycle start pulse on unit_start[k]. unit_done[k] is
// sampled only while waiting on unit k. A level held over from an earlier op
// is harmless because it is never sampled before the matching start pulse.
module fpu_issue_ctrl #(
   parameter int WIDTH     = 32,
   parameter int NUM_UNITS = 3,
   parameter int OP_W      = 3,
   parameter int TIMEOUT   = 64
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       op_valid,
   input  logic [OP_W-1:0]            op_code,
   input  logic [WIDTH-1:0]           op_a,
   input  logic [WIDTH-1:0]           op_b,
   output logic                       stall,
   output logic                       res_valid,
   output logic [WIDTH-1:0]           res_data,
   output logic [1:0]                 res_err,
   output logic [NUM_UNITS-1:0]       unit_start,
   output logic [WIDTH-1:0]           unit_a,
   output logic [WIDTH-1:0]           unit_b,
   input  logic [NUM_UNITS-1:0]       unit_done,
   input  logic [NUM_UNITS*WIDTH-1:0] unit_result,
   output logic [1:0]                 dbg_state
);

   localparam int CNT_W = $clog2(TIMEOUT) + 1;

   localparam logic [1:0] ERR_OK      = 2'b00;
   localparam logic [1:0] ERR_ILLEGAL = 2'b01;
   localparam logic [1:0] ERR_TIMEOUT = 2'b10;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t               state;
   logic [OP_W-1:0]      sel;
   logic [CNT_W-1:0]     wait_cnt;
   logic [NUM_UNITS-1:0] start_r;

   logic                 op_req;
   logic                 op_legal;
   logic [NUM_UNITS-1:0] start_vec;
   logic                 sel_done;
   logic [WIDTH-1:0]     sel_result;

   // Opcode decode for the incoming op and the mux for the selected unit's done and result
   always_comb begin
      op_req     = op_valid && (op_code != '0);
      op_legal   = (op_code <= OP_W'(NUM_UNITS));
      start_vec  = '0;
      sel_done   = 1'b0;
      sel_result = '0;
      for (int i = 0; i < NUM_UNITS; i++) begin
         start_vec[i] = (op_code == OP_W'(i + 1));
         if (sel == OP_W'(i)) begin
            sel_done   = unit_done[i];
            sel_result = unit_result[i*WIDTH +: WIDTH];
         end
      end
   end

   // Issue FSM: operand latching, start pulse, wait counter and registered result
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         sel       <= '0;
         wait_cnt  <= '0;
         start_r   <= '0;
         unit_a    <= '0;
         unit_b    <= '0;
         res_valid <= 1'b0;
         res_data  <= '0;
         res_err   <= ERR_OK;
      end else begin
         start_r   <= '0;
         res_valid <= 1'b0;
         case (state)
            S_IDLE: begin
               if (op_req) begin
                  unit_a <= op_a;
                  unit_b <= op_b;
                  sel    <= op_code - OP_W'(1);
                  if (op_legal) begin
                     // Register the pulse now so it is visible during ISSUE
                     start_r <= start_vec;
                     state   <= S_ISSUE;
                  end else begin
                     res_valid <= 1'b1;
                     res_data  <= '0;
                     res_err   <= ERR_ILLEGAL;
                     state     <= S_DONE;
                  end
               end
            end
            S_ISSUE: begin
               wait_cnt <= '0;
               state    <= S_WAIT;
            end
            S_WAIT: begin
               if (sel_done) begin
                  res_valid <= 1'b1;
                  res_data  <= sel_result;
                  res_err   <= ERR_OK;
                  state     <= S_DONE;
               end else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
                  res_valid <= 1'b1;
                  res_data  <= '0;
                  res_err   <= ERR_TIMEOUT;
                  state     <= S_DONE;
               end else begin
                  wait_cnt <= wait_cnt + CNT_W'(1);
               end
            end
            S_DONE: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   // Stall covers op acceptance in IDLE plus ISSUE and WAIT, and releases in DONE
   always_comb begin
      stall = ((state == S_IDLE) && op_req) || (state == S_ISSUE) || (state == S_WAIT);
   end

   // The start pulse is suppressed in any reset cycle
   assign unit_start = start_r & {NUM_UNITS{~rst}};
   assign dbg_state  = state;

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// tb_fpu_issue_ctrl: bench for fpu_issue_ctrl with mock execution units and a
// transaction-age reference model. It runs directed scenarios and then
// randomized traffic with random resets.
`timescale 1ns/1ps
module tb_fpu_issue_ctrl;

   localparam int W   = 32;
   localparam int NU  = 3;
   localparam int OPW = 3;
   localparam int TO  = 8;

   // ---------------- clock / reset / DUT ----------------
   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            op_valid = 1'b0;
   logic [OPW-1:0]  op_code = '0;
   logic [W-1:0]    op_a = '0;
   logic [W-1:0]    op_b = '0;
   logic            stall;
   logic            res_valid;
   logic [W-1:0]    res_data;
   logic [1:0]      res_err;
   logic [NU-1:0]   unit_start;
   logic [W-1:0]    unit_a;
   logic [W-1:0]    unit_b;
   logic [NU-1:0]   unit_done = '0;
   logic [NU*W-1:0] unit_result = '0;
   logic [1:0]      dbg_state;

   always #5 clk = ~clk;

   fpu_issue_ctrl #(.WIDTH(W), .NUM_UNITS(NU), .OP_W(OPW), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst), .op_valid(op_valid), .op_code(op_code),
      .op_a(op_a), .op_b(op_b), .stall(stall), .res_valid(res_valid),
      .res_data(res_data), .res_err(res_err), .unit_start(unit_start),
      .unit_a(unit_a), .unit_b(unit_b), .unit_done(unit_done),
      .unit_result(unit_result), .dbg_state(dbg_state)
   );

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- mock execution units ----------------
   int          cyc = 0;
   int          sched [NU];
   int          mock_delay [NU];
   logic [W-1:0] mock_res [NU];
   logic [NU-1:0] force_mask = '0;
   bit          rand_mode = 0;

   initial begin
      for (int i = 0; i < NU; i++) begin
         sched[i] = -1;
         mock_delay[i] = 0;
         mock_res[i] = '0;
      end
   end

   // Units see their start pulse and schedule a one-cycle done pulse
   always @(negedge clk) begin
      for (int i = 0; i < NU; i++) begin
         if (rst) sched[i] = -1;
         else if (unit_start[i]) begin
            if (rand_mode) sched[i] = cyc + $urandom_range(1, 10);
            else sched[i] = (mock_delay[i] == 0) ? -1 : cyc + mock_delay[i];
         end
      end
   end

   // Units drive done and result just after each rising edge
   always @(posedge clk) begin
      #1;
      cyc++;
      for (int i = 0; i < NU; i++) begin
         unit_done[i] = (sched[i] == cyc) || force_mask[i] ||
                        (rand_mode && ($urandom_range(0, 15) == 0));
         unit_result[i*W +: W] = rand_mode ? W'($urandom) : mock_res[i];
      end
   end

   // ---------------- reference model (transaction age based) ----------------
   // m_age: cycles since the op was accepted (-1 = no op in flight)
   // m_fin: age at which res_valid must be seen (-1 = not decided yet)
   int           m_age = -1;
   int           m_fin = -1;
   bit           m_ill = 0;
   int           m_sel = 0;
   logic [W-1:0] m_data = '0;
   logic [W-1:0] m_a = '0;
   logic [W-1:0] m_b = '0;
   logic [1:0]   m_err = '0;
   bit           model_on = 0;

   always @(negedge clk) begin
      bit          free;
      bit          e_stall;
      bit          e_rv;
      logic [NU-1:0] e_start;
      if (model_on) begin
         if (rst) begin
            chk("start_in_reset", 64'(unit_start), 64'd0);
         end else begin
            free    = (m_age < 0);
            e_stall = free ? (op_valid && (op_code != 0)) : !(m_fin >= 0 && m_age == m_fin);
            e_start = (!free && !m_ill && m_age == 1) ? NU'(1 << m_sel) : '0;
            e_rv    = !free && (m_fin >= 0) && (m_age == m_fin);
            chk("stall", 64'(stall), 64'(e_stall));
            chk("unit_start", 64'(unit_start), 64'(e_start));
            chk("res_valid", 64'(res_valid), 64'(e_rv));
            chk("res_data", 64'(res_data), 64'(m_data));
            chk("res_err", 64'(res_err), 64'(m_err));
            chk("unit_a", 64'(unit_a), 64'(m_a));
            chk("unit_b", 64'(unit_b), 64'(m_b));
         end
      end
      if (rst) begin
         model_on = 1;
         m_age = -1; m_fin = -1;
         m_data = '0; m_err = '0; m_a = '0; m_b = '0;
      end else if (model_on) begin
         if (m_age < 0) begin
            if (op_valid && op_code != 0) begin
               m_a = op_a; m_b = op_b;
               m_sel = int'(op_code) - 1;
               m_ill = (int'(op_code) > NU);
               m_age = 1;
               if (m_ill) begin
                  m_fin = 1; m_data = '0; m_err = 2'd1;
               end else begin
                  m_fin = -1;
               end
            end
         end else begin
            // Wait window covers ages 2 .. TO+1; the result lands one cycle after the decision
            if (!m_ill && m_fin < 0 && m_age >= 2) begin
               if (unit_done[m_sel]) begin
                  m_fin = m_age + 1; m_data = unit_result[m_sel*W +: W]; m_err = 2'd0;
               end else if (m_age == TO + 1) begin
                  m_fin = TO + 2; m_data = '0; m_err = 2'd2;
               end
            end
            if (m_age == m_fin) m_age = -1;
            else m_age++;
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic idle(input int n);
      op_valid = 1'b0;
      op_code  = '0;
      repeat (n) begin
         @(posedge clk); #1;
      end
   endtask

   // Present an op and hold it until the core is released, observing the DUT
   task automatic run_op(input logic [OPW-1:0] code, input logic [W-1:0] a, input logic [W-1:0] b,
                         output int n_stall, output logic [NU-1:0] starts, output int n_starts,
                         output logic [W-1:0] data, output logic [1:0] err, output int n_rv);
      int guard;
      op_valid = 1'b1; op_code = code; op_a = a; op_b = b;
      n_stall = 0; starts = '0; n_starts = 0; data = 'x; err = 'x; n_rv = 0;
      guard = 0;
      forever begin
         @(negedge clk);
         guard++;
         if (unit_start != '0) begin
            n_starts++;
            starts |= unit_start;
         end
         if (res_valid) begin
            n_rv++; data = res_data; err = res_err;
         end
         if (stall) n_stall++;
         else break;
         if (guard > 40) begin
            errors++; checks++;
            $display("FAIL op_bound: no release after %0d cycles, required <= 40", guard);
            break;
         end
      end
      @(posedge clk); #1;
   endtask

   // ---------------- main sequence ----------------
   int            ns, nst, nrv, st_a, st_b;
   logic [NU-1:0] sv;
   logic [W-1:0]  d;
   logic [1:0]    e;

   initial begin
      repeat (3) @(posedge clk);
      #1; rst = 1'b0;
      idle(2);

      // 1: unit0 done 3 cycles after start
      mock_delay[0] = 3; mock_res[0] = 32'h40400000;
      run_op(3'd1, 32'h3F800000, 32'h40000000, ns, sv, nst, d, e, nrv);
      chk("t1_stall_cycles", 64'(ns), 64'd5);
      chk("t1_start_vec", 64'(sv), 64'b001);
      chk("t1_start_count", 64'(nst), 64'd1);
      chk("t1_rv_count", 64'(nrv), 64'd1);
      chk("t1_data", 64'(d), 64'h40400000);
      chk("t1_err", 64'(e), 64'd0);
      idle(2);

      // 2: unit2 done after 1 cycle, units 0/1 assert done throughout
      mock_delay[2] = 1; mock_res[2] = 32'h40C00000;
      mock_res[0] = 32'hDEAD0000; mock_res[1] = 32'hBEEF0000;
      force_mask = 3'b011;
      run_op(3'd3, 32'h40A00000, 32'h3F800000, ns, sv, nst, d, e, nrv);
      force_mask = '0;
      chk("t2_stall_cycles", 64'(ns), 64'd3);
      chk("t2_start_vec", 64'(sv), 64'b100);
      chk("t2_start_count", 64'(nst), 64'd1);
      chk("t2_data", 64'(d), 64'h40C00000);
      chk("t2_err", 64'(e), 64'd0);
      idle(2);

      // 3: reset while waiting on a unit that never finishes
      mock_delay[0] = 0;
      op_valid = 1'b1; op_code = 3'd1; op_a = 32'h12345678; op_b = 32'h9ABCDEF0;
      repeat (4) @(negedge clk);
      @(posedge clk); #1;
      rst = 1'b1; op_valid = 1'b0; op_code = '0;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("t3_stall", 64'(stall), 64'd0);
      chk("t3_res_valid", 64'(res_valid), 64'd0);
      chk("t3_res_data", 64'(res_data), 64'd0);
      chk("t3_unit_a", 64'(unit_a), 64'd0);
      chk("t3_unit_b", 64'(unit_b), 64'd0);
      @(posedge clk); #1;
      mock_delay[0] = 2; mock_res[0] = 32'h11111111;
      run_op(3'd1, 32'h1, 32'h2, ns, sv, nst, d, e, nrv);
      chk("t3_post_data", 64'(d), 64'h11111111);
      chk("t3_post_stall", 64'(ns), 64'd4);
      idle(2);

      // 4: illegal opcode
      run_op(3'd5, 32'hAAAA5555, 32'h5555AAAA, ns, sv, nst, d, e, nrv);
      chk("t4_stall_cycles", 64'(ns), 64'd1);
      chk("t4_start_count", 64'(nst), 64'd0);
      chk("t4_data", 64'(d), 64'd0);
      chk("t4_err", 64'(e), 64'd1);
      idle(2);

      // 5: timeout on unit1
      mock_delay[1] = 0;
      run_op(3'd2, 32'h3, 32'h4, ns, sv, nst, d, e, nrv);
      chk("t5_stall_cycles", 64'(ns), 64'(TO + 2));
      chk("t5_start_vec", 64'(sv), 64'b010);
      chk("t5_data", 64'(d), 64'd0);
      chk("t5_err", 64'(e), 64'd2);
      idle(1);
      @(negedge clk);
      chk("t5_back_idle", 64'(stall), 64'd0);
      @(posedge clk); #1;

      // 6: back-to-back ops with op_valid held high
      mock_delay[0] = 2; mock_res[0] = 32'hCAFE0001;
      mock_delay[2] = 4; mock_res[2] = 32'hCAFE0003;
      run_op(3'd1, 32'h10, 32'h20, ns, sv, nst, d, e, nrv);
      st_a = nst;
      chk("t6_first_data", 64'(d), 64'hCAFE0001);
      run_op(3'd3, 32'h30, 32'h40, ns, sv, nst, d, e, nrv);
      st_b = nst;
      chk("t6_second_data", 64'(d), 64'hCAFE0003);
      chk("t6_second_vec", 64'(sv), 64'b100);
      chk("t6_total_starts", 64'(st_a + st_b), 64'd2);
      chk("t6_rv_count", 64'(nrv), 64'd1);
      idle(2);

      // 7: randomized traffic, the core holds the op while stalled
      rand_mode = 1;
      for (int n = 0; n < 3000; n++) begin
         bit s;
         @(negedge clk);
         s = stall;
         @(posedge clk); #1;
         rst = ($urandom_range(0, 199) == 0);
         if (!s || rst) begin
            op_valid = ($urandom_range(0, 3) != 0);
            op_code  = OPW'($urandom_range(0, 7));
            op_a     = W'($urandom);
            op_b     = W'($urandom);
         end
      end
      rst = 1'b0;
      rand_mode = 0;
      idle(20);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Absolute time limit
   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation exceeded time limit, required completion");
      $fatal(1);
   end

endmodule
